move_seq_packer: RTL

- Writer side of the packed move-sequence bus (`ord`/`comp`) that feeds the 7-segment move display.
- Accepts 2-bit move codes from the 8-puzzle solver as push/pop strobes, so a backtracking search can undo moves.
- Keeps the partial path as a stack, packed into a flat vector.
- On commit, freezes the vector and raises `comp`; the display then steps through the moves.

---
 rtl/move_seq_packer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/move_seq_packer.sv
// Writer side of the packed move-sequence bus feeding the move display.
// Holds the solver's partial path as a stack packed into a flat vector.
// Push/pop strobes let a backtracking search undo moves. Commit freezes
// the path and raises comp so the display can step through it. Clear
// discards the path and starts a new empty one.
module move_seq_packer #(
    parameter int MAX_MOVES = 17,
    parameter int MW        = 2,
    parameter int LW        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [MW-1:0]           mv,
    input  logic                    pop,
    input  logic                    commit,
    input  logic                    clear,
    output logic [MAX_MOVES*MW-1:0] ord,
    output logic [LW-1:0]           len,
    output logic [MW-1:0]           top_mv,
    output logic                    top_vld,
    output logic                    full,
    output logic                    empty,
    output logic                    comp,
    output logic                    err
);

    localparam int              OW      = MAX_MOVES * MW;
    localparam logic [LW-1:0]   LEN_MAX = LW'(MAX_MOVES);

    typedef enum logic {
        BUILD = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t          state;
    logic [OW-1:0]   nxt_ord;
    logic [LW-1:0]   nxt_len;
    logic            op_err;
    logic            wr_en;
    logic [LW-1:0]   wr_idx;
    logic [MW-1:0]   wr_val;
    logic [LW-1:0]   top_idx;

    // Status flags come straight from the registered length.
    assign full    = (len == LEN_MAX);
    assign empty   = (len == '0);
    assign top_vld = !empty;
    assign top_idx = len - LW'(1);

    // Top-of-stack readout: select slot len-1, or zero when the stack is empty.
    always_comb begin
        top_mv = '0;
        for (int k = 0; k < MAX_MOVES; k++) begin
            if (top_vld && (top_idx == LW'(k))) begin
                top_mv = ord[MW*k +: MW];
            end
        end
    end

    // Stack operation decode: choose the single slot write and the new length.
    // A push with a pop on a non-empty stack replaces the top slot. On an empty
    // stack it is treated as a plain push.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        nxt_len = len;
        op_err  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_val  = '0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
            wr_val = mv;
        end else if (push) begin
            if (full) begin
                op_err = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = len;
                wr_val  = mv;
                nxt_len = len + LW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                op_err = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = top_idx;
                wr_val  = '0;
                nxt_len = top_idx;
            end
        end
    end

    // Per-slot write enable decoded from the slot index. A popped slot is
    // written back to zero, so every slot at or above len always reads zero.
    always_comb begin
        nxt_ord = ord;
        for (int k = 0; k < MAX_MOVES; k++) begin
            if (wr_en && (wr_idx == LW'(k))) begin
                nxt_ord[MW*k +: MW] = wr_val;
            end
        end
    end

    // Control FSM and output registers. Clear overrides any stack op or
    // commit in the same cycle. In BUILD the stack op is applied first and a
    // same-cycle commit then freezes the updated path.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge inputs.
        if (!rst_n) begin
            state <= BUILD;
            ord   <= '0;
            len   <= '0;
            comp  <= 1'b0;
            err   <= 1'b0;
        end else if (clear) begin
            state <= BUILD;
            ord   <= '0;
            len   <= '0;
            comp  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                BUILD: begin
                    ord <= nxt_ord;
                    len <= nxt_len;
                    if (op_err) begin
                        err <= 1'b1;
                    end
                    if (commit) begin
                        state <= DONE;
                        comp  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= BUILD;
                end
            endcase
        end
    end

endmodule
